// File: rtl/enc_pkg.sv
// Shared definitions for the sequential request encoder.
//   enc_state_t          : FSM state encoding (IDLE, DRAIN)
//   MAX_N                : widest request vector the helpers handle
//   idx_width()          : index width for an N-bit request vector
//   onehot_count_is_one(): true when a vector has exactly one bit set
package enc_pkg;

  typedef enum logic {IDLE, DRAIN} enc_state_t;

  localparam int MAX_N = 64;

  // Index width for an n-bit vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic onehot_count_is_one(input logic [MAX_N-1:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

endpackage

// File: rtl/req_encoder_if.sv
// Handshake bundle of the request encoder.
//   req_valid/req_ready/req_vec : upstream vector handshake
//   idx_valid/idx_ready/idx     : downstream index handshake
//   idx_last                    : current index is the final one of the vector
//   busy                        : a vector is held and not yet drained
//   state                       : FSM state, exported for observation
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high; valid never waits on ready, and a
// producer holds its payload stable while valid is high and ready is low.
interface req_encoder_if import enc_pkg::*; #(
  parameter int N = 8
) ();

  localparam int W = idx_width(N);

  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_vec;
  logic         idx_valid;
  logic         idx_ready;
  logic [W-1:0] idx;
  logic         idx_last;
  logic         busy;
  enc_state_t   state;

  // Encoder side.
  modport slave (
    input  req_valid, req_vec, idx_ready,
    output req_ready, idx_valid, idx, idx_last, busy, state
  );

  // Upstream/downstream side.
  modport master (
    output req_valid, req_vec, idx_ready,
    input  req_ready, idx_valid, idx, idx_last, busy, state
  );

endinterface

// File: rtl/prio_enc.sv
// Combinational priority encoder.
//   vec : N-bit input vector
//   idx : index of the lowest (LSB_FIRST=1) or highest (LSB_FIRST=0) set bit,
//         zero when vec is zero
//   any : vec has at least one bit set
module prio_enc import enc_pkg::*; #(
  parameter int N         = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic [N-1:0]              vec,
  output logic [idx_width(N)-1:0]   idx,
  output logic                      any
);

  localparam int W = idx_width(N);

  // Scan away from the winning end so the last hit is the winner.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (LSB_FIRST != 0) begin
        if (vec[N-1-i]) idx = W'(N - 1 - i);
      end else begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/req_encoder.sv
// Sequential priority encoder: latches a multi-hot request vector and emits
// the index of every set bit, one per accepted output beat, in priority order.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : req_encoder_if.slave (request handshake, index handshake,
//              idx_last, busy, state)
// All outputs are decoded from state_q and pending_q only.
module req_encoder import enc_pkg::*; #(
  parameter int N         = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst,
  req_encoder_if.slave  bus
);

  localparam int W = idx_width(N);

  enc_state_t   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] idx_w;
  logic         pend_any;
  logic         last_w;
  logic [N-1:0] clr_mask;

  prio_enc #(.N(N), .LSB_FIRST(LSB_FIRST)) u_prio (
    .vec (pending_q),
    .idx (idx_w),
    .any (pend_any)
  );

  assign last_w = pend_any && onehot_count_is_one(MAX_N'(pending_q));

  // Bit to retire on an accepted output beat.
  always_comb begin
    clr_mask        = '0;
    clr_mask[idx_w] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        // An all-zero vector is consumed without producing any beat.
        if (bus.req_valid && (bus.req_vec != '0)) begin
          pending_d = bus.req_vec;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.idx_ready) begin
          pending_d = pending_q & ~clr_mask;
          if (last_w) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.idx_valid = (state_q == DRAIN);
  assign bus.busy      = (state_q == DRAIN);
  assign bus.idx       = idx_w;
  assign bus.idx_last  = last_w;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_req_encoder.sv
// Bench for req_encoder: one LSB-first and one MSB-first instance (N=8).
module tb_req_encoder;
  import enc_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [3:0] exp_q[$];   // {idx_last, idx}
  logic [3:0] exp;

  req_encoder_if #(.N(8)) if_l ();
  req_encoder_if #(.N(8)) if_m ();

  req_encoder #(.N(8), .LSB_FIRST(1)) dut_l (.clk(clk), .rst(rst), .bus(if_l));
  req_encoder #(.N(8), .LSB_FIRST(0)) dut_m (.clk(clk), .rst(rst), .bus(if_m));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  // Called at a negedge; holds req_valid until accepted, returns at the
  // negedge of the cycle after the accepting edge with req_valid low.
  task automatic drive_vec(input bit sel, input logic [7:0] v, output bit ok);
    int c;
    ok = 1'b0;
    c  = 0;
    if (sel) begin if_m.req_valid = 1'b1; if_m.req_vec = v; end
    else     begin if_l.req_valid = 1'b1; if_l.req_vec = v; end
    while (!ok && c < 50) begin
      if ((sel ? if_m.req_ready : if_l.req_ready) === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    @(negedge clk);
    if (sel) if_m.req_valid = 1'b0;
    else     if_l.req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit ok;
    @(negedge clk);
    rst = 1'b0;
    if_l.idx_ready = 1'b0;
    drive_vec(1'b0, 8'h0C, ok);
    checks++;
    if (!ok || if_l.idx_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_setup: accepted=%b idx_valid=%b, want 1 1", ok, if_l.idx_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({if_l.req_ready, if_l.idx_valid, if_l.idx, if_l.idx_last, if_l.busy} !== 7'b1_0_000_0_0) begin
      failures++;
      $display("FAIL reset_async: ready=%b valid=%b idx=%0d last=%b busy=%b, want 1 0 0 0 0",
               if_l.req_ready, if_l.idx_valid, if_l.idx, if_l.idx_last, if_l.busy);
    end
    checks++;
    if (if_l.state !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d want IDLE", if_l.state);
    end
    @(posedge clk); #1;
    checks++;
    if ({if_m.req_ready, if_m.idx_valid, if_m.idx, if_m.idx_last, if_m.busy} !== 7'b1_0_000_0_0) begin
      failures++;
      $display("FAIL reset_hold: ready=%b valid=%b idx=%0d last=%b busy=%b, want 1 0 0 0 0",
               if_m.req_ready, if_m.idx_valid, if_m.idx, if_m.idx_last, if_m.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    if_l.idx_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_basic();
    bit ok;
    exp_q.push_back({1'b0, 3'd2});
    exp_q.push_back({1'b0, 3'd5});
    exp_q.push_back({1'b1, 3'd7});
    drive_vec(1'b0, 8'b1010_0100, ok);
    for (int b = 0; b < 3; b++) begin
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
      checks++;
      if (!ok || {if_l.idx_valid, if_l.idx_last, if_l.idx} !== {1'b1, exp}) begin
        failures++;
        $display("FAIL basic_beat%0d: valid=%b last=%b idx=%0d, want valid=1 last=%b idx=%0d",
                 b, if_l.idx_valid, if_l.idx_last, if_l.idx, exp[3], exp[2:0]);
      end
      @(negedge clk);
    end
    checks++;
    if (if_l.req_ready !== 1'b1 || if_l.idx_valid !== 1'b0 || if_l.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: ready=%b valid=%b busy=%b, want 1 0 0",
               if_l.req_ready, if_l.idx_valid, if_l.busy);
    end
  endtask

  task automatic test_stall();
    bit ok;
    if_l.idx_ready = 1'b0;
    exp_q.push_back({1'b0, 3'd2});
    exp_q.push_back({1'b0, 3'd5});
    exp_q.push_back({1'b1, 3'd7});
    drive_vec(1'b0, 8'b1010_0100, ok);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (!ok || {if_l.idx_valid, if_l.idx_last, if_l.idx} !== {1'b1, exp_q[0]}) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b last=%b idx=%0d, want valid=1 last=%b idx=%0d",
                 s, if_l.idx_valid, if_l.idx_last, if_l.idx, exp_q[0][3], exp_q[0][2:0]);
      end
      @(negedge clk);
    end
    if_l.idx_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
      checks++;
      if ({if_l.idx_valid, if_l.idx_last, if_l.idx} !== {1'b1, exp}) begin
        failures++;
        $display("FAIL stall_beat%0d: valid=%b last=%b idx=%0d, want valid=1 last=%b idx=%0d",
                 b, if_l.idx_valid, if_l.idx_last, if_l.idx, exp[3], exp[2:0]);
      end
      @(negedge clk);
    end
    checks++;
    if (if_l.req_ready !== 1'b1 || if_l.idx_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_done: ready=%b valid=%b, want 1 0", if_l.req_ready, if_l.idx_valid);
    end
  endtask

  task automatic test_zero();
    bit ok;
    drive_vec(1'b0, 8'h00, ok);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (!ok || if_l.idx_valid !== 1'b0 || if_l.req_ready !== 1'b1 || if_l.busy !== 1'b0) begin
        failures++;
        $display("FAIL zero_vec%0d: accepted=%b valid=%b ready=%b busy=%b, want 1 0 1 0",
                 c, ok, if_l.idx_valid, if_l.req_ready, if_l.busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_msb_back_to_back();
    bit ok;
    for (int i = 7; i >= 0; i--) exp_q.push_back({(i == 0), 3'(i)});
    drive_vec(1'b1, 8'hFF, ok);
    // Second vector offered while the first is still draining.
    if_m.req_valid = 1'b1;
    if_m.req_vec   = 8'h0F;
    for (int b = 0; b < 8; b++) begin
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
      checks++;
      if (!ok || {if_m.idx_valid, if_m.idx_last, if_m.idx, if_m.req_ready} !== {1'b1, exp, 1'b0}) begin
        failures++;
        $display("FAIL msb_beat%0d: valid=%b last=%b idx=%0d ready=%b, want valid=1 last=%b idx=%0d ready=0",
                 b, if_m.idx_valid, if_m.idx_last, if_m.idx, if_m.req_ready, exp[3], exp[2:0]);
      end
      @(negedge clk);
    end
    checks++;
    if (if_m.req_ready !== 1'b1 || if_m.idx_valid !== 1'b0) begin
      failures++;
      $display("FAIL msb_gap: ready=%b valid=%b, want 1 0", if_m.req_ready, if_m.idx_valid);
    end
    for (int i = 3; i >= 0; i--) exp_q.push_back({(i == 0), 3'(i)});
    @(negedge clk);
    if_m.req_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
      checks++;
      if ({if_m.idx_valid, if_m.idx_last, if_m.idx} !== {1'b1, exp}) begin
        failures++;
        $display("FAIL msb_second%0d: valid=%b last=%b idx=%0d, want valid=1 last=%b idx=%0d",
                 b, if_m.idx_valid, if_m.idx_last, if_m.idx, exp[3], exp[2:0]);
      end
      @(negedge clk);
    end
    checks++;
    if (if_m.req_ready !== 1'b1 || if_m.idx_valid !== 1'b0) begin
      failures++;
      $display("FAIL msb_done: ready=%b valid=%b, want 1 0", if_m.req_ready, if_m.idx_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    exp_q.push_back({1'b0, 3'd3});
    drive_vec(1'b0, 8'b0001_1000, ok);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
    checks++;
    if (!ok || {if_l.idx_valid, if_l.idx_last, if_l.idx} !== {1'b1, exp}) begin
      failures++;
      $display("FAIL midrst_first: valid=%b last=%b idx=%0d, want valid=1 last=%b idx=%0d",
               if_l.idx_valid, if_l.idx_last, if_l.idx, exp[3], exp[2:0]);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({if_l.req_ready, if_l.idx_valid, if_l.idx, if_l.idx_last, if_l.busy} !== 7'b1_0_000_0_0) begin
      failures++;
      $display("FAIL midrst_clear: ready=%b valid=%b idx=%0d last=%b busy=%b, want 1 0 0 0 0",
               if_l.req_ready, if_l.idx_valid, if_l.idx, if_l.idx_last, if_l.busy);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back({1'b1, 3'd1});
    drive_vec(1'b0, 8'b0000_0010, ok);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
    checks++;
    if (!ok || {if_l.idx_valid, if_l.idx_last, if_l.idx} !== {1'b1, exp}) begin
      failures++;
      $display("FAIL midrst_next: valid=%b last=%b idx=%0d, want valid=1 last=%b idx=%0d",
               if_l.idx_valid, if_l.idx_last, if_l.idx, exp[3], exp[2:0]);
    end
    @(negedge clk);
    checks++;
    if (if_l.req_ready !== 1'b1 || if_l.idx_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_done: ready=%b valid=%b, want 1 0", if_l.req_ready, if_l.idx_valid);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    if_l.req_valid = 1'b0;
    if_l.req_vec   = '0;
    if_l.idx_ready = 1'b1;
    if_m.req_valid = 1'b0;
    if_m.req_vec   = '0;
    if_m.idx_ready = 1'b1;
    repeat (2) @(posedge clk);

    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_msb_back_to_back();
    test_reset_mid_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
